// File: rtl/slave_frame_decoder_pkg.sv
// ---------------------------------------------------------------------------
// slave_frame_decoder_pkg
// Shared constants for the I2C-slave frame decoder: opcode field values,
// ASCII display strings for each opcode and the FSM state encodings.
// ---------------------------------------------------------------------------
package slave_frame_decoder_pkg;

  // Opcode field (bits [1:0] of word 0); upper opcode bits are don't-care.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Opcode mnemonics as packed ASCII for the OLED driver.
  localparam logic [31:0] ASC_ADD = 32'h4144_4400; // "ADD\0"
  localparam logic [31:0] ASC_SUB = 32'h5355_4200; // "SUB\0"
  localparam logic [31:0] ASC_MUL = 32'h4D55_4C00; // "MUL\0"
  localparam logic [31:0] ASC_NOP = 32'h6E6F_6F70; // "noop"

  // FSM state encodings, visible on state_out.
  localparam logic [2:0] S_COLLECT = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_MULT    = 3'd2;
  localparam logic [2:0] S_UPDATE  = 3'd3;

  // Words per frame: opcode, operand A, operand B, remote result.
  localparam int NUM_WORDS = 4;

  function automatic logic [31:0] op_ascii(input logic [1:0] op);
    logic [31:0] asc;
    unique case (op)
      OP_ADD:  asc = ASC_ADD;
      OP_SUB:  asc = ASC_SUB;
      OP_MUL:  asc = ASC_MUL;
      default: asc = ASC_NOP;
    endcase
    return asc;
  endfunction

endpackage

// File: rtl/slave_frame_decoder_pulse_sync.sv
// ---------------------------------------------------------------------------
// pulse_sync
// Brings an asynchronous level/pulse into the clk domain through a 2-flop
// synchroniser and emits a one-cycle strobe on its rising edge.
//   clk      in  clock
//   rst_n    in  async active-low reset (all flops to 0)
//   async_i  in  asynchronous input level
//   pulse_o  out one-cycle strobe, high 3 clk edges after async_i rises
//                (registered on the third edge)
// ---------------------------------------------------------------------------
module pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, sync3_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the shift chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // sync1 may be metastable; only sync2/sync3 feed logic.
  assign pulse_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/slave_frame_decoder.sv
// ---------------------------------------------------------------------------
// slave_frame_decoder
// Collects a 4-word frame (opcode, A, B, remote result) from the I2C slave
// receiver, decodes the opcode, runs MUL on an external multiplier over a
// start/done handshake and updates the OLED display registers atomically.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rx_done, rx_data    receive-complete (async to clk) and received word
//   mult_a/b/start      multiplier operands and one-cycle start pulse
//   mult_done/result    multiplier completion pulse and product
//   oled_a/b/result     displayed operands and result
//   oled_opcode         opcode as ASCII
//   frame_valid         one-cycle pulse when oled_* update
//   frame_cnt           completed-frame counter (wraps)
//   word_idx, state_out debug: next expected word, FSM state
//   overrun             sticky: word arrived outside S_COLLECT
//   timeout_err         sticky: partial frame aborted by inter-word timeout
//
// Optional feature: define FRAME_TIMEOUT_EN to abort partial frames whose
// inter-word gap reaches TIMEOUT_CYC clk cycles. Without it timeout_err is 0
// and a partial frame waits indefinitely.
// ---------------------------------------------------------------------------
module slave_frame_decoder
  import slave_frame_decoder_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] mult_a,
  output logic [DATA_W-1:0] mult_b,
  output logic              mult_start,
  input  logic              mult_done,
  input  logic [DATA_W-1:0] mult_result,
  output logic [DATA_W-1:0] oled_a,
  output logic [DATA_W-1:0] oled_b,
  output logic [DATA_W-1:0] oled_result,
  output logic [31:0]       oled_opcode,
  output logic              frame_valid,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [1:0]        word_idx,
  output logic [2:0]        state_out,
  output logic              overrun,
  output logic              timeout_err
);

  logic              strobe;
  logic              tmo_expire;
  logic [2:0]        state_q, state_d;
  logic [1:0]        word_idx_q, word_idx_d;
  logic [DATA_W-1:0] word_q [NUM_WORDS];
  logic [DATA_W-1:0] prod_q;
  logic [DATA_W-1:0] mult_a_q, mult_b_q;
  logic              mult_start_q;
  logic [DATA_W-1:0] oled_a_q, oled_b_q, oled_result_q;
  logic [31:0]       oled_opcode_q;
  logic              frame_valid_q;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic              overrun_q;
  logic [1:0]        opcode;

  assign opcode = word_q[0][1:0];

  pulse_sync u_rx_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (rx_done),
    .pulse_o (strobe)
  );

  // Next-state logic for the FSM and the word pointer.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs; a missing
    // branch would otherwise infer a latch.
    state_d    = state_q;
    word_idx_d = word_idx_q;
    case (state_q)
      S_COLLECT: begin
        if (strobe) begin
          word_idx_d = word_idx_q + 2'd1;   // wraps 3 -> 0
          if (word_idx_q == 2'd3) state_d = S_DECODE;
        end else if (tmo_expire) begin
          word_idx_d = 2'd0;
        end
      end
      S_DECODE: state_d = (opcode == OP_MUL) ? S_MULT : S_UPDATE;
      S_MULT:   if (mult_done) state_d = S_UPDATE;
      S_UPDATE: state_d = S_COLLECT;
      default:  state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_COLLECT;
      word_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
    end
  end

  // Datapath: word capture, multiplier handshake, display registers, flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the small word store is reset on purpose so a reset mid-frame
      // discards partial words; large RAM-style arrays would not be.
      for (int i = 0; i < NUM_WORDS; i++) word_q[i] <= '0;
      prod_q        <= '0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      mult_start_q  <= 1'b0;
      oled_a_q      <= '0;
      oled_b_q      <= '0;
      oled_result_q <= '0;
      oled_opcode_q <= '0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
      overrun_q     <= 1'b0;
    end else begin
      mult_start_q  <= 1'b0;
      frame_valid_q <= 1'b0;

      if (state_q == S_COLLECT) begin
        if (strobe) begin
          word_q[word_idx_q] <= rx_data;
        end else if (tmo_expire) begin
          for (int i = 0; i < NUM_WORDS; i++) word_q[i] <= '0;
        end
      end else if (strobe) begin
        // Word dropped: the frame in flight is left untouched.
        overrun_q <= 1'b1;
      end

      case (state_q)
        S_DECODE: begin
          if (opcode == OP_MUL) begin
            mult_a_q     <= word_q[1];
            mult_b_q     <= word_q[2];
            mult_start_q <= 1'b1;
          end
        end
        S_MULT: begin
          if (mult_done) prod_q <= mult_result;
        end
        S_UPDATE: begin
          oled_a_q      <= word_q[1];
          oled_b_q      <= word_q[2];
          oled_opcode_q <= op_ascii(opcode);
          case (opcode)
            OP_MUL:  oled_result_q <= prod_q;
            OP_NOP:  oled_result_q <= DATA_W'(8'hFF);
            default: oled_result_q <= word_q[3];
          endcase
          frame_valid_q <= 1'b1;
          frame_cnt_q   <= frame_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_run;
  logic             timeout_err_q;

  // Only a partially received frame is timed; a strobe restarts the gap.
  assign tmo_run    = (state_q == S_COLLECT) && (word_idx_q != 2'd0);
  // A strobe on the expiry cycle wins: the word is taken, no timeout.
  assign tmo_expire = tmo_run && !strobe && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (!tmo_run || strobe || tmo_expire) tmo_cnt_q <= '0;
      else                                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (tmo_expire) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo_expire  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign mult_start  = mult_start_q;
  assign oled_a      = oled_a_q;
  assign oled_b      = oled_b_q;
  assign oled_result = oled_result_q;
  assign oled_opcode = oled_opcode_q;
  assign frame_valid = frame_valid_q;
  assign frame_cnt   = frame_cnt_q;
  assign word_idx    = word_idx_q;
  assign state_out   = state_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/slave_frame_decoder.md
Name: slave_frame_decoder

Overview:
- Parametrised successor to the I2C-slave processing FSM.
- Collects a 4-word frame (opcode, operand A, operand B, remote result) from the I2C slave receiver, decodes the opcode and drives the OLED display registers.
- For MUL, it launches an external multiplier over a start/done handshake.
- Fully synchronous to clk: the receiver's done strobe is synchronised and edge-detected, never used as a clock.

Parameters:
- DATA_W, 32, width of each received word, of the operand outputs and of the result outputs.
- CNT_W, 16, width of the completed-frame counter.
- TIMEOUT_CYC, 1000000, maximum clk cycles allowed between words of one frame. Used only with FRAME_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- rx_done  in  1  receive-complete level/pulse from the I2C slave; asynchronous to clk
- rx_data  in  DATA_W  received word; stable from rx_done rise until the next receive starts
- mult_a  out  DATA_W  multiplier operand A
- mult_b  out  DATA_W  multiplier operand B
- mult_start  out  1  one-cycle multiplier start pulse
- mult_done  in  1  multiplier completion pulse
- mult_result  in  DATA_W  product; valid while mult_done=1
- oled_a  out  DATA_W  displayed operand A
- oled_b  out  DATA_W  displayed operand B
- oled_result  out  DATA_W  displayed result
- oled_opcode  out  32  opcode as ASCII
- frame_valid  out  1  one-cycle pulse when the oled_* outputs update
- frame_cnt  out  CNT_W  number of completed frames; wraps
- word_idx  out  2  index of the next expected word (0..3)
- state_out  out  3  FSM state encoding
- overrun  out  1  sticky flag: a word arrived outside S_COLLECT
- timeout_err  out  1  sticky flag: a frame was aborted by timeout (FRAME_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset (rst_n=0, async): all outputs, captured words, word_idx and both flags go to 0; state=S_COLLECT; synchroniser flops go to 0.
- Word strobe:
  - rx_done passes through a 2-flop synchroniser, then a rising-edge detector (sync2 & ~sync3).
  - The strobe is high exactly 1 cycle, 3 clk edges after rx_done rises.
  - rx_data is captured on the strobe cycle.
- States and encoding: S_COLLECT=0, S_DECODE=1, S_MULT=2, S_UPDATE=3.
- S_COLLECT:
  - On a strobe, store rx_data into slot word_idx (0 opcode, 1 A, 2 B, 3 result), then word_idx++.
  - On the strobe with word_idx==3: word_idx wraps to 0 and state -> S_DECODE.
- S_DECODE (1 cycle), on opcode[1:0]:
  - 10 (MUL): drive mult_a=A, mult_b=B, pulse mult_start for 1 cycle -> S_MULT.
  - All other opcodes -> S_UPDATE.
- S_MULT:
  - Hold mult_a and mult_b.
  - On mult_done, latch mult_result -> S_UPDATE.
  - There is no timeout here; mult_done is guaranteed by the multiplier.
- S_UPDATE (1 cycle):
  - Load oled_a=A and oled_b=B.
  - Load oled_opcode / oled_result per opcode:
    - 00: 0x41444400 ("ADD"), result = word 3
    - 01: 0x53554200 ("SUB"), result = word 3
    - 10: 0x4D554C00 ("MUL"), result = latched product
    - 11: 0x6E6F6F70 ("noop"), result = 0xFF zero-extended
  - Pulse frame_valid and increment frame_cnt (wraps to 0 from all-ones); -> S_COLLECT.
- Overrun: a strobe in S_DECODE, S_MULT or S_UPDATE is dropped and overrun is set. Only reset clears it. word_idx is unaffected.
- Opcode bits above [1:0] are ignored.
- oled_* outputs hold their previous frame's values until the next S_UPDATE; they never show a partial frame.
- A strobe and the S_UPDATE cycle coinciding counts as overrun.
- Reset mid-frame discards all partial words.
- state_out = state; word_idx is visible for debug.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- Defined:
  - In S_COLLECT with word_idx!=0, a cycle counter runs and restarts on each strobe.
  - When it reaches TIMEOUT_CYC, word_idx goes to 0, partial words are discarded and timeout_err is set (sticky).
  - A strobe in the same cycle as expiry wins: the word is accepted and there is no timeout.
- Undefined: no counter logic exists, timeout_err is constant 0, and a partial frame waits indefinitely.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_NOP=2'b11;
  - ASCII constants ASC_ADD, ASC_SUB, ASC_MUL, ASC_NOP;
  - state encodings S_COLLECT..S_UPDATE.
- One sub-module: pulse_sync (2-flop synchroniser plus rising-edge detector, async active-low reset), reusable elsewhere.
- The multiplier stays external.

Test Plan:
- ADD frame: words 0x0, 0x3F800000, 0x40000000, 0x40400000 -> oled_opcode=0x41444400, oled_result=0x40400000, frame_valid 1 cycle, frame_cnt=1.
- MUL frame: opcode 0x2, A=0x40000000, B=0x40400000; bench multiplier returns mult_done 5 cycles after mult_start with 0x40C00000 -> exactly one mult_start pulse, oled_result=0x40C00000; word 3 is ignored.
- NOP frame, then a SUB frame back-to-back -> first update shows 0x6E6F6F70 / 0x000000FF, second shows 0x53554200; frame_cnt=2.
- Strobe injected during S_MULT -> overrun=1, frame completes normally, word_idx stays 0.
- rst_n asserted after 2 words -> all outputs 0 immediately (async); a following full frame decodes correctly.
- FRAME_TIMEOUT_EN with TIMEOUT_CYC=50: 2 words, then a 60-cycle gap -> timeout_err=1, word_idx=0; the next 4 words form a correct frame.
